md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- Processor-side initiator for the multiply/divide unit.
- Accepts one mult/div request from the execute stage and latches its operands and destination register.
- Issues a single-cycle ctrl_MULT or ctrl_DIV start pulse, holds the operands stable, and stalls the pipeline until data_resultRDY arrives.
- Then presents a one-cycle writeback; on exception, the writeback is redirected to the status register.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, register index width.
- EXC_REG, 30, destination register for exception codes.
- MULT_EXC_CODE, 4, value written on multiply exception (overflow).
- DIV_EXC_CODE, 5, value written on divide exception (divide by zero).
- TIMEOUT_CYCLES, 64, watchdog limit (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a mult/div op.
- req_is_div  in  1  1 = divide, 0 = multiply.
- req_operandA  in  DATA_WIDTH  first operand.
- req_operandB  in  DATA_WIDTH  second operand.
- req_rd  in  REG_ADDR_WIDTH  destination register.
- req_ready  out  1  block idle; request accepted this cycle if req_valid.
- stall  out  1  freeze the upstream pipeline.
- md_operandA  out  DATA_WIDTH  to unit data_operandA; registered.
- md_operandB  out  DATA_WIDTH  to unit data_operandB; registered.
- md_ctrl_MULT  out  1  one-cycle start pulse, multiply.
- md_ctrl_DIV  out  1  one-cycle start pulse, divide.
- md_result  in  DATA_WIDTH  from unit data_result.
- md_exception  in  1  from unit data_exception.
- md_resultRDY  in  1  from unit data_resultRDY.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  REG_ADDR_WIDTH  writeback register.
- wb_data  out  DATA_WIDTH  writeback value.
- wb_exception  out  1  writeback carries an exception code.

Behaviour:
- Reset values: state IDLE; md_operandA/B = 0; md_ctrl_MULT/DIV = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; wb_exception = 0; stall = 0; req_ready = 1.
- The FSM has four states: IDLE, START, WAIT and DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch operands, req_rd and req_is_div, then go to START.
- START (exactly 1 cycle):
  - md_ctrl_MULT = ~op_is_div; md_ctrl_DIV = op_is_div.
  - md_resultRDY is ignored in this cycle, since a stale RDY from the previous op may still be high.
  - Go to WAIT.
- WAIT:
  - Start pulses = 0; operands held stable.
  - The first cycle with md_resultRDY = 1 captures md_result and md_exception, then goes to DONE.
- DONE (exactly 1 cycle):
  - wb_valid = 1.
  - If no exception: wb_rd = latched rd, wb_data = captured result, wb_exception = 0.
  - If exception: wb_rd = EXC_REG, wb_data = MULT_EXC_CODE or DIV_EXC_CODE (zero-extended to DATA_WIDTH), wb_exception = 1.
  - Return to IDLE.
- Writeback outputs are registered. Outside DONE: wb_valid = 0; wb_rd/wb_data/wb_exception hold their last values.
- stall = 1 in START and WAIT; 0 in IDLE and DONE.
- Latency: accept at cycle t, pulse at t+1; wb_valid at t+2+N, where N = cycles from pulse to first qualified RDY (N ≥ 1).
- Back-to-back requests: no request is accepted in DONE. The next accept is the following IDLE cycle, so the minimum issue interval is 4 cycles.
- req_rd = 0 is not special-cased; the writeback consumer ignores r0.
- Reset mid-operation (any state): return to IDLE next cycle with no wb_valid and no further start pulse. The unit's in-flight result is discarded; the next START restarts the unit.
- Exactly one of md_ctrl_MULT/md_ctrl_DIV may be high in any cycle; both are 0 outside START.

Optional Feature:
- Macro: MD_TIMEOUT_EN.
- With the macro defined: a WAIT cycle counter runs. If md_resultRDY has not arrived after TIMEOUT_CYCLES WAIT cycles, go to DONE with wb_exception = 1, wb_rd = EXC_REG, and the op's exception code.
- Without the macro: no counter; WAIT lasts indefinitely.

Decomposition:
- Shared package md_pkg holds:
  - the state enum (IDLE/START/WAIT/DONE);
  - constants EXC_REG, MULT_EXC_CODE and DIV_EXC_CODE;
  - the op encoding (OP_MULT = 0, OP_DIV = 1).
- One sub-module, md_wait_counter: clearable up-counter with a terminal-count flag. It is instantiated only under MD_TIMEOUT_EN.

Test Plan:
- Multiply: req A = 7, B = 6, rd = 3, RDY 17 cycles after the pulse → one md_ctrl_MULT pulse at t+1; stall high t+1..t+18; wb_valid at t+19 with rd = 3, data = 42.
- Divide by zero: A = 100, B = 0, is_div, rd = 8, unit raises exception → wb_rd = 30, wb_data = 5, wb_exception = 1; r8 not written.
- Multiply overflow: A = 0x40000000, B = 4, exception → wb_rd = 30, wb_data = 4.
- Stale RDY: md_resultRDY held high during START, low for 5 cycles, then high with result 9 → writeback data = 9 taken from the later RDY, never the stale value.
- Reset in WAIT: assert reset 3 cycles after the pulse → next cycle IDLE, stall = 0, no wb_valid. A following request 20/4 (div) writes back 5.
- MD_TIMEOUT_EN: RDY never asserted on a divide → wb_valid TIMEOUT_CYCLES (64) WAIT cycles after the START cycle, with wb_rd = 30, data = 5.

Source files
------------

// File: rtl/md_pkg.sv
// Shared state/op encodings and exception constants for the multiply/divide issue controller.
package md_pkg;

  localparam int EXC_REG        = 30;
  localparam int MULT_EXC_CODE  = 4;
  localparam int DIV_EXC_CODE   = 5;
  localparam int TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } md_state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } md_op_e;

  function automatic int exc_code(input md_op_e op);
    return (op == OP_DIV) ? DIV_EXC_CODE : MULT_EXC_CODE;
  endfunction

endpackage

// File: rtl/md_wait_counter.sv
// Clearable up-counter with terminal-count flag; bounds the WAIT state.
// Only present in builds with MD_TIMEOUT_EN defined.
`ifdef MD_TIMEOUT_EN
module md_wait_counter #(
  parameter int LIMIT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // tc marks the LIMIT-th enabled cycle; the count saturates there.
  assign tc = (count_q == CW'(LIMIT - 1));

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: latch request, pulse start, stall, write back.
// Optional watchdog on the WAIT state is enabled with MD_TIMEOUT_EN.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_is_div,
  input  logic [DATA_WIDTH-1:0]     req_operandA,
  input  logic [DATA_WIDTH-1:0]     req_operandB,
  input  logic [REG_ADDR_WIDTH-1:0] req_rd,
  output logic                      req_ready,
  output logic                      stall,
  output logic [DATA_WIDTH-1:0]     md_operandA,
  output logic [DATA_WIDTH-1:0]     md_operandB,
  output logic                      md_ctrl_MULT,
  output logic                      md_ctrl_DIV,
  input  logic [DATA_WIDTH-1:0]     md_result,
  input  logic                      md_exception,
  input  logic                      md_resultRDY,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      wb_exception
);

  localparam logic [REG_ADDR_WIDTH-1:0] EXC_RD = REG_ADDR_WIDTH'(EXC_REG);

  md_state_e                 state_q, state_d;
  md_op_e                    op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0]     opa_q, opa_d;
  logic [DATA_WIDTH-1:0]     opb_q, opb_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
  logic                      wb_exc_q, wb_exc_d;
  logic [DATA_WIDTH-1:0]     exc_data;

  assign exc_data = DATA_WIDTH'(exc_code(op_q));

`ifdef MD_TIMEOUT_EN
  logic wait_en;
  logic wait_clr;
  logic wait_tc;

  assign wait_en  = (state_q == WAIT);
  assign wait_clr = (state_q != WAIT);

  md_wait_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clock(clock),
    .reset(reset),
    .clr  (wait_clr),
    .en   (wait_en),
    .tc   (wait_tc)
  );
`endif

  // Handshake: a request transfers on any rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and req_valid is not required to stay up afterwards.
  assign req_ready    = (state_q == IDLE);
  assign stall        = (state_q == START) || (state_q == WAIT);
  assign md_ctrl_MULT = (state_q == START) && (op_q == OP_MULT);
  assign md_ctrl_DIV  = (state_q == START) && (op_q == OP_DIV);
  assign md_operandA  = opa_q;
  assign md_operandB  = opb_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_exception = wb_exc_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_exc_d   = wb_exc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = md_op_e'(req_is_div);
          rd_d    = req_rd;
          opa_d   = req_operandA;
          opb_d   = req_operandB;
          state_d = START;
        end
      end
      // RDY is deliberately not looked at here: it may still be high from the previous op.
      START: state_d = WAIT;
      WAIT: begin
        if (md_resultRDY) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          if (md_exception) begin
            wb_rd_d   = EXC_RD;
            wb_data_d = exc_data;
            wb_exc_d  = 1'b1;
          end else begin
            wb_rd_d   = rd_q;
            wb_data_d = md_result;
            wb_exc_d  = 1'b0;
          end
        end
`ifdef MD_TIMEOUT_EN
        else if (wait_tc) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_rd_d    = EXC_RD;
          wb_data_d  = exc_data;
          wb_exc_d   = 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      rd_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_exc_q   <= wb_exc_d;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: vector table, reset/timeout sequences and random ops vs a writeback model.
module tb_md_issue_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int WBW = AW + DW + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_is_div;
  logic [DW-1:0] req_operandA;
  logic [DW-1:0] req_operandB;
  logic [AW-1:0] req_rd;
  logic          req_ready;
  logic          stall;
  logic [DW-1:0] md_operandA;
  logic [DW-1:0] md_operandB;
  logic          md_ctrl_MULT;
  logic          md_ctrl_DIV;
  logic [DW-1:0] md_result;
  logic          md_exception;
  logic          md_resultRDY;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_exception;

  int n_checks = 0;
  int n_errors = 0;

  logic [WBW-1:0] exp_q[$];

  typedef struct {
    bit            is_div;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [AW-1:0] rd;
    int            n;
    bit            stale;
    logic [AW-1:0] exp_rd;
    logic [DW-1:0] exp_data;
    bit            exp_exc;
  } vec_t;

  vec_t vecs[6];

  md_issue_ctrl #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_WIDTH(AW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_is_div  (req_is_div),
    .req_operandA(req_operandA),
    .req_operandB(req_operandB),
    .req_rd      (req_rd),
    .req_ready   (req_ready),
    .stall       (stall),
    .md_operandA (md_operandA),
    .md_operandB (md_operandB),
    .md_ctrl_MULT(md_ctrl_MULT),
    .md_ctrl_DIV (md_ctrl_DIV),
    .md_result   (md_result),
    .md_exception(md_exception),
    .md_resultRDY(md_resultRDY),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_exception(wb_exception)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Stand-in for the arithmetic unit: what it returns for an op (result, exception).
  function automatic logic [DW:0] unit_resp(input bit is_div, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [2*DW-1:0] p;
    if (is_div) begin
      if (b == '0) return {{DW{1'b0}}, 1'b1};
      return {a / b, 1'b0};
    end
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    return {p[DW-1:0], (p[2*DW-1:DW] != '0)};
  endfunction

  // Writeback the controller must produce for a given unit response.
  function automatic logic [WBW-1:0] model_wb(input bit is_div, input logic [AW-1:0] rd,
                                              input logic [DW-1:0] res, input bit exc);
    if (exc) return {5'd30, (is_div ? 32'd5 : 32'd4), 1'b0} | WBW'(1);
    return {rd, res, 1'b0};
  endfunction

  // scoreboard: every writeback strobe must match the oldest expected entry
  always @(negedge clock) begin : wb_monitor
    logic [WBW-1:0] e;
    if (reset === 1'b0 && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=%0h, required no writeback",
                 wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        chk("wb_fields", {wb_rd, wb_data, wb_exception}, e);
      end
    end
  end

  // Driver: called at a negedge in an IDLE cycle; returns at the negedge of the next IDLE cycle.
  task automatic run_op(input bit is_div, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [AW-1:0] rd, input int n, input bit stale, input bit never,
                        input logic [DW-1:0] res, input bit exc, input logic [WBW-1:0] exp_wb);
    chk("ready_idle", req_ready, 1);
    chk("stall_idle", stall, 0);
    req_valid    = 1'b1;
    req_is_div   = is_div;
    req_operandA = a;
    req_operandB = b;
    req_rd       = rd;
    exp_q.push_back(exp_wb);
    @(negedge clock);
    req_valid    = 1'b0;
    req_operandA = $urandom;
    req_operandB = $urandom;
    req_rd       = AW'($urandom_range(0, 31));
    md_resultRDY = stale;
    md_exception = stale;
    md_result    = 32'hBAD0_BAD0;
    chk("start_mult", md_ctrl_MULT, !is_div);
    chk("start_div", md_ctrl_DIV, is_div);
    chk("start_stall", stall, 1);
    chk("start_ready", req_ready, 0);
    chk("start_opA", md_operandA, a);
    chk("start_opB", md_operandB, b);
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      md_resultRDY = !never && (k == n);
      md_result    = (k == n) ? res : DW'($urandom);
      md_exception = (k == n) ? exc : 1'b0;
      chk("wait_pulses", {md_ctrl_MULT, md_ctrl_DIV}, 0);
      chk("wait_stall", stall, 1);
      chk("wait_wb", wb_valid, 0);
      chk("wait_opA", md_operandA, a);
    end
    @(negedge clock);
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    chk("done_wb_valid", wb_valid, 1);
    chk("done_stall", stall, 0);
    chk("done_ready", req_ready, 0);
    chk("done_pulses", {md_ctrl_MULT, md_ctrl_DIV}, 0);
    @(negedge clock);
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_ready", req_ready, 1);
    chk("idle_wb_hold", {wb_rd, wb_data, wb_exception}, exp_wb);
  endtask

  initial begin : main
    logic [DW:0]    r;
    logic [WBW-1:0] e;
    bit             is_div;
    logic [DW-1:0]  a, b;
    logic [AW-1:0]  rd;

    vecs[0] = '{1'b0, 32'd7,          32'd6,   5'd3,  17, 1'b0, 5'd3,  32'd42, 1'b0};
    vecs[1] = '{1'b1, 32'd100,        32'd0,   5'd8,  4,  1'b0, 5'd30, 32'd5,  1'b1};
    vecs[2] = '{1'b0, 32'h4000_0000,  32'd4,   5'd5,  2,  1'b1, 5'd30, 32'd4,  1'b1};
    vecs[3] = '{1'b1, 32'd81,         32'd9,   5'd12, 6,  1'b1, 5'd12, 32'd9,  1'b0};
    vecs[4] = '{1'b0, 32'd3,          32'd5,   5'd0,  1,  1'b0, 5'd0,  32'd15, 1'b0};
    vecs[5] = '{1'b1, 32'd20,         32'd4,   5'd7,  1,  1'b1, 5'd7,  32'd5,  1'b0};

    reset        = 1'b1;
    req_valid    = 1'b0;
    req_is_div   = 1'b0;
    req_operandA = '0;
    req_operandB = '0;
    req_rd       = '0;
    md_result    = '0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_pulses", {md_ctrl_MULT, md_ctrl_DIV}, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_fields", {wb_rd, wb_data, wb_exception}, 0);
    chk("rst_operands", {md_operandA, md_operandB}, 0);
    reset = 1'b0;
    @(negedge clock);

    // directed vector table
    foreach (vecs[i]) begin
      r = unit_resp(vecs[i].is_div, vecs[i].a, vecs[i].b);
      run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].n, vecs[i].stale, 1'b0,
             r[DW:1], r[0], {vecs[i].exp_rd, vecs[i].exp_data, vecs[i].exp_exc});
    end

    // reset asserted three cycles after the start pulse
    req_valid    = 1'b1;
    req_is_div   = 1'b1;
    req_operandA = 32'd50;
    req_operandB = 32'd5;
    req_rd       = 5'd9;
    @(negedge clock);
    req_valid = 1'b0;
    chk("abort_div_pulse", md_ctrl_DIV, 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_stall", stall, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_pulses", {md_ctrl_MULT, md_ctrl_DIV}, 0);
    md_resultRDY = 1'b1;
    md_result    = 32'd10;
    @(negedge clock);
    chk("abort_no_wb", wb_valid, 0);
    chk("abort_no_pulse", {md_ctrl_MULT, md_ctrl_DIV}, 0);
    chk("abort_idle_stall", stall, 0);
    run_op(1'b1, 32'd20, 32'd4, 5'd11, 3, 1'b1, 1'b0, 32'd5, 1'b0, {5'd11, 32'd5, 1'b0});

    // random ops checked against the writeback model
    for (int i = 0; i < 24; i++) begin
      is_div = 1'($urandom_range(0, 1));
      a      = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 1000));
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = DW'($urandom);
        default: b = DW'($urandom_range(1, 70000));
      endcase
      rd = AW'($urandom_range(0, 31));
      r  = unit_resp(is_div, a, b);
      e  = model_wb(is_div, rd, r[DW:1], r[0]);
      run_op(is_div, a, b, rd, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'b0,
             r[DW:1], r[0], e);
    end

`ifdef MD_TIMEOUT_EN
    // unit never answers a divide: watchdog forces an exception writeback
    run_op(1'b1, 32'd9, 32'd3, 5'd14, 64, 1'b0, 1'b1, 32'd3, 1'b0, {5'd30, 32'd5, 1'b1});
`endif

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
